fir_filter: RTL and testbench



---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_filter_if.sv | 11 +
 rtl/fir_delay_line.sv | 25 ++
 rtl/fir_filter.sv | 49 ++++
 tb/tb_fir_filter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the 8-tap symmetric low-pass FIR filter.
// Coefficients sum to 1 << SHIFT, so the DC gain is unity.
package fir_pkg;

  localparam int DATA_W = 12;
  localparam int TAPS   = 8;
  localparam int SHIFT  = 6;
  localparam int ACC_W  = 19;
  localparam int COEF_W = 5;

  localparam logic [ACC_W-1:0] ROUND = 19'd32;

  localparam logic [COEF_W-1:0] COEF [0:TAPS-1] = '{
    5'd2, 5'd4, 5'd8, 5'd18, 5'd18, 5'd8, 5'd4, 5'd2
  };

endpackage

// File: rtl/fir_filter_if.sv
// Sample stream into and filtered stream out of the FIR filter.
// Both directions are valid on every clock, so there is no handshake.
interface fir_filter_if;

  logic [fir_pkg::DATA_W-1:0] X_in;
  logic [fir_pkg::DATA_W-1:0] Y_out;

  modport master (output X_in, input Y_out);
  modport slave  (input X_in, output Y_out);

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep shift register of DATA_W samples with async active-low clear.
// Every stage is exposed so that the MAC can read the full history.
module fir_delay_line #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 12
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [DATA_W-1:0]             din,
  output logic [TAPS-1:0][DATA_W-1:0]   taps_r
);

  // Shift the newest sample into stage 0 and age the others by one.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      taps_r <= '0;
    end else begin
      taps_r[0] <= din;
      for (int k = 1; k < TAPS; k++) begin
        taps_r[k] <= taps_r[k-1];
      end
    end
  end

endmodule

// File: rtl/fir_filter.sv
// 8-tap symmetric low-pass FIR: one 12-bit sample in and one rounded,
// normalised 12-bit result out on every clock.
module fir_filter
  import fir_pkg::*;
(
  input  logic         clk,
  input  logic         nReset,
  fir_filter_if.slave  bus
);

  logic [TAPS-1:0][DATA_W-1:0] taps_s;
  logic [DATA_W:0]             pre_s;
  logic [ACC_W-1:0]            acc_s;
  logic [DATA_W-1:0]           y_next_s;
  logic [DATA_W-1:0]           y_r;

  fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_delay_line (
    .clk    (clk),
    .nReset (nReset),
    .din    (bus.X_in),
    .taps_r (taps_s)
  );

  // Symmetric pre-add then MAC; relies on COEF[k] == COEF[TAPS-1-k].
  always_comb begin
    pre_s = '0;
    acc_s = ROUND;
    for (int k = 0; k < TAPS / 2; k++) begin
      pre_s = {1'b0, taps_s[k]} + {1'b0, taps_s[TAPS-1-k]};
      acc_s = acc_s + (ACC_W'(COEF[k]) * ACC_W'(pre_s));
    end
    y_next_s = DATA_W'(acc_s >> SHIFT);
  end

  // Output register, cleared with the history.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      y_r <= '0;
    end else begin
      y_r <= y_next_s;
    end
  end

  assign bus.Y_out = y_r;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed impulse/step/reset cases plus
// random samples against a convolution model of the sample history.
module tb_fir_filter;

  logic clk;
  logic nReset;
  int   checks;
  int   failures;

  int   coef [0:7] = '{2, 4, 8, 18, 18, 8, 4, 2};
  int   hist [$];
  int   imp_tab  [0:7] = '{2, 4, 8, 18, 18, 8, 4, 2};
  int   step_tab [0:7] = '{31, 94, 219, 500, 781, 906, 969, 1000};
  logic [11:0] y;

  fir_filter_if bus ();

  fir_filter dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output after the next edge: rounded convolution of prior samples.
  function automatic logic [11:0] model_y();
    int acc;
    acc = 32;
    for (int k = 0; k < 8; k++) begin
      if (k < hist.size()) acc += coef[k] * hist[k];
    end
    return 12'(acc / 64);
  endfunction

  task automatic drive(input logic [11:0] x, output logic [11:0] yo);
    logic [11:0] exp;
    bus.X_in = x;
    exp = model_y();
    hist.push_front(int'(x));
    if (hist.size() > 8) void'(hist.pop_back());
    @(posedge clk);
    #1;
    yo = bus.Y_out;
    check("model", yo, exp);
  endtask

  task automatic hold_reset(input int n);
    nReset = 1'b0;
    hist.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", bus.Y_out, 12'd0);
    end
    nReset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nReset   = 1'b0;
    bus.X_in = 12'd4095;

    // Reset held with full-scale input toggling the clock.
    hold_reset(4);

    // Impulse of 64 reproduces the coefficients.
    drive(12'd64, y);
    for (int i = 0; i < 8; i++) begin
      drive(12'd0, y);
      check("impulse", y, 12'(imp_tab[i]));
    end
    drive(12'd0, y);
    check("impulse_tail", y, 12'd0);

    // Step of 1000.
    drive(12'd1000, y);
    for (int i = 0; i < 8; i++) begin
      drive(12'd1000, y);
      check("step", y, 12'(step_tab[i]));
    end
    drive(12'd1000, y);
    check("step_settled", y, 12'd1000);

    // Full scale settles without wrapping.
    for (int i = 0; i < 12; i++) drive(12'd4095, y);
    check("full_scale", y, 12'd4095);

    // Asynchronous reset assertion between edges clears the output at once.
    #2;
    nReset = 1'b0;
    hist.delete();
    #1;
    check("async_rst", bus.Y_out, 12'd0);
    hold_reset(1);

    // Single full-scale impulse.
    drive(12'd4095, y);
    drive(12'd0, y);
    check("fs_impulse", y, 12'd128);
    for (int i = 0; i < 8; i++) drive(12'd0, y);

    // Ramp, mid-stream reset pulse, then an impulse with no residue.
    for (int i = 0; i <= 200; i++) drive(12'(i), y);
    hold_reset(1);
    drive(12'd64, y);
    for (int i = 0; i < 8; i++) begin
      drive(12'd0, y);
      check("post_rst_impulse", y, 12'(imp_tab[i]));
    end
    drive(12'd0, y);
    check("post_rst_tail", y, 12'd0);

    // Random 8-bit samples against the model.
    for (int i = 0; i < 10000; i++) begin
      drive(12'($urandom_range(0, 255)), y);
    end

    // Random full 12-bit samples for wider coverage of the accumulator.
    for (int i = 0; i < 500; i++) begin
      drive(12'($urandom_range(0, 4095)), y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
